// File: rtl/sccomp.sv
// Single-cycle MIPS-subset computer: instruction ROM, data RAM and register file around a one-clock datapath.
// Every instruction commits PC, register and memory writes on one rising edge; there is no backpressure.

module sccomp_im (
  input  logic [6:0]  addr,
  output logic [31:0] dout
);
  logic [31:0] ROM [0:127];

  assign dout = ROM[addr];
endmodule

module sccomp (
  input  logic        clk,
  input  logic        rstn,
  input  logic [4:0]  reg_sel,
  output logic [31:0] reg_data
);
  logic [31:0] PC;
  logic [31:0] instr;
  logic [31:0] rf [0:31];
  logic [31:0] dm [0:127];

  sccomp_im U_IM (.addr(PC[8:2]), .dout(instr));

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [25:0] target;
  logic [31:0] rs_val, rt_val, imm_s, imm_z, pc_plus4;
  logic [31:0] alu_res, wr_data, next_pc;
  logic [4:0]  wr_addr;
  logic        rf_we, dm_we, mem_to_reg;

  assign op       = instr[31:26];
  assign rs       = instr[25:21];
  assign rt       = instr[20:16];
  assign rd       = instr[15:11];
  assign shamt    = instr[10:6];
  assign funct    = instr[5:0];
  assign imm      = instr[15:0];
  assign target   = instr[25:0];
  assign imm_s    = {{16{imm[15]}}, imm};
  assign imm_z    = {16'h0000, imm};
  assign pc_plus4 = PC + 32'd4;

  assign rs_val   = (rs == 5'd0) ? 32'd0 : rf[rs];
  assign rt_val   = (rt == 5'd0) ? 32'd0 : rf[rt];
  assign reg_data = (reg_sel == 5'd0) ? 32'd0 : rf[reg_sel];

  always_comb begin
    alu_res    = 32'd0;
    rf_we      = 1'b0;
    dm_we      = 1'b0;
    mem_to_reg = 1'b0;
    wr_addr    = rt;
    next_pc    = pc_plus4;
    case (op)
      6'h00: begin
        wr_addr = rd;
        rf_we   = 1'b1;
        case (funct)
          6'h20, 6'h21: alu_res = rs_val + rt_val;
          6'h22, 6'h23: alu_res = rs_val - rt_val;
          6'h24: alu_res = rs_val & rt_val;
          6'h25: alu_res = rs_val | rt_val;
          6'h26: alu_res = rs_val ^ rt_val;
          6'h27: alu_res = ~(rs_val | rt_val);
          6'h2a: alu_res = {31'd0, $signed(rs_val) < $signed(rt_val)};
          6'h2b: alu_res = {31'd0, rs_val < rt_val};
          6'h00: alu_res = rt_val << shamt;
          6'h02: alu_res = rt_val >> shamt;
          6'h03: alu_res = $unsigned($signed(rt_val) >>> shamt);
          6'h08: begin
            rf_we   = 1'b0;
            next_pc = rs_val;
          end
          default: rf_we = 1'b0;
        endcase
      end
      6'h08, 6'h09: begin alu_res = rs_val + imm_s; rf_we = 1'b1; end
      6'h0a: begin alu_res = {31'd0, $signed(rs_val) < $signed(imm_s)}; rf_we = 1'b1; end
      6'h0c: begin alu_res = rs_val & imm_z; rf_we = 1'b1; end
      6'h0d: begin alu_res = rs_val | imm_z; rf_we = 1'b1; end
      6'h0e: begin alu_res = rs_val ^ imm_z; rf_we = 1'b1; end
      6'h0f: begin alu_res = {imm, 16'h0000}; rf_we = 1'b1; end
      6'h23: begin alu_res = rs_val + imm_s; rf_we = 1'b1; mem_to_reg = 1'b1; end
      6'h2b: begin alu_res = rs_val + imm_s; dm_we = 1'b1; end
      6'h04: if (rs_val == rt_val) next_pc = pc_plus4 + {imm_s[29:0], 2'b00};
      6'h05: if (rs_val != rt_val) next_pc = pc_plus4 + {imm_s[29:0], 2'b00};
      6'h02: next_pc = {pc_plus4[31:28], target, 2'b00};
      6'h03: begin
        next_pc = {pc_plus4[31:28], target, 2'b00};
        alu_res = pc_plus4;
        wr_addr = 5'd31;
        rf_we   = 1'b1;
      end
      default: ;
    endcase
  end

  assign wr_data = mem_to_reg ? dm[alu_res[8:2]] : alu_res;

  // Reset wins over the in-flight instruction, so its writes are dropped.
  always_ff @(posedge clk) begin
    if (rstn) begin
      PC <= 32'd0;
      for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
    end else begin
      PC <= next_pc;
      if (rf_we && wr_addr != 5'd0) rf[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn && dm_we) dm[alu_res[8:2]] <= rt_val;
  end
endmodule

// File: tb/tb_sccomp.sv
// Bench for sccomp: directed programs plus random programs, checked against an instruction-level interpreter.
module tb_sccomp;
  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic [4:0]  reg_sel = 5'd0;
  logic [31:0] reg_data;

  int errors = 0;
  int checks = 0;

  logic [31:0] prog  [0:127];
  logic [31:0] m_rom [0:127];
  logic [31:0] m_rf  [0:31];
  logic [31:0] m_dm  [0:127];
  logic [31:0] m_pc;

  sccomp dut (.clk(clk), .rstn(rstn), .reg_sel(reg_sel), .reg_data(reg_data));

  always #50 clk = ~clk;

  function automatic logic [31:0] r_t(input logic [5:0] fn, input logic [4:0] s, input logic [4:0] t,
                                      input logic [4:0] d, input logic [4:0] sh);
    return {6'h00, s, t, d, sh, fn};
  endfunction

  function automatic logic [31:0] i_t(input logic [5:0] o, input logic [4:0] s, input logic [4:0] t,
                                      input logic [15:0] im);
    return {o, s, t, im};
  endfunction

  function automatic logic [31:0] j_t(input logic [5:0] o, input logic [25:0] tg);
    return {o, tg};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Instruction-set interpreter: one call executes the instruction at m_pc.
  task automatic m_step();
    logic [31:0] ins, a, b, se, ze, pc4, npc, wv, ea;
    logic [4:0]  wa;
    logic        we;
    ins = m_rom[m_pc[8:2]];
    a   = (ins[25:21] == 0) ? 32'd0 : m_rf[ins[25:21]];
    b   = (ins[20:16] == 0) ? 32'd0 : m_rf[ins[20:16]];
    se  = {{16{ins[15]}}, ins[15:0]};
    ze  = {16'd0, ins[15:0]};
    pc4 = m_pc + 32'd4;
    npc = pc4;
    we  = 1'b0;
    wa  = ins[20:16];
    wv  = 32'd0;
    ea  = a + se;
    case (ins[31:26])
      6'h00: begin
        wa = ins[15:11];
        we = 1'b1;
        case (ins[5:0])
          6'h20, 6'h21: wv = a + b;
          6'h22, 6'h23: wv = a - b;
          6'h24: wv = a & b;
          6'h25: wv = a | b;
          6'h26: wv = a ^ b;
          6'h27: wv = ~(a | b);
          6'h2a: wv = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          6'h2b: wv = (a < b) ? 32'd1 : 32'd0;
          6'h00: wv = b << ins[10:6];
          6'h02: wv = b >> ins[10:6];
          6'h03: wv = $unsigned($signed(b) >>> ins[10:6]);
          6'h08: begin we = 1'b0; npc = a; end
          default: we = 1'b0;
        endcase
      end
      6'h08, 6'h09: begin wv = a + se; we = 1'b1; end
      6'h0a: begin wv = ($signed(a) < $signed(se)) ? 32'd1 : 32'd0; we = 1'b1; end
      6'h0c: begin wv = a & ze; we = 1'b1; end
      6'h0d: begin wv = a | ze; we = 1'b1; end
      6'h0e: begin wv = a ^ ze; we = 1'b1; end
      6'h0f: begin wv = ze << 16; we = 1'b1; end
      6'h23: begin wv = m_dm[ea[8:2]]; we = 1'b1; end
      6'h2b: m_dm[ea[8:2]] = b;
      6'h04: if (a == b) npc = pc4 + (se << 2);
      6'h05: if (a != b) npc = pc4 + (se << 2);
      6'h02: npc = {pc4[31:28], ins[25:0], 2'b00};
      6'h03: begin npc = {pc4[31:28], ins[25:0], 2'b00}; wa = 5'd31; wv = pc4; we = 1'b1; end
      default: ;
    endcase
    if (we && wa != 0) m_rf[wa] = wv;
    m_pc = npc;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 128; i++) prog[i] = 32'd0;
  endtask

  task automatic boot();
    rstn = 1'b1;
    for (int i = 0; i < 128; i++) begin
      dut.U_IM.ROM[i] = prog[i];
      m_rom[i] = prog[i];
    end
    @(posedge clk);
    #1;
    rstn = 1'b0;
    m_pc = 32'd0;
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
  endtask

  task automatic run(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      m_step();
      @(posedge clk);
      #1;
      check(tag, dut.PC, m_pc);
    end
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 32; i++) begin
      reg_sel = 5'(i);
      #1;
      check(tag, reg_data, m_rf[i]);
    end
  endtask

  task automatic check_reg(input string tag, input logic [4:0] r, input logic [31:0] exp);
    reg_sel = r;
    #1;
    check(tag, reg_data, exp);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0]  r_fn [0:12] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                 6'h2a, 6'h2b, 6'h00, 6'h02, 6'h03};
    logic [5:0]  i_op [0:6]  = '{6'h08, 6'h09, 6'h0a, 6'h0c, 6'h0d, 6'h0e, 6'h0f};
    logic [4:0]  s, t, d, sh;
    logic [15:0] im, off;
    s   = 5'($urandom);
    t   = 5'($urandom);
    d   = 5'($urandom);
    sh  = 5'($urandom);
    im  = 16'($urandom);
    off = 16'($urandom_range(0, 10)) - 16'd3;
    case ($urandom_range(0, 19))
      0, 1, 2, 3, 18, 19: return r_t(r_fn[$urandom_range(0, 12)], s, t, d, sh);
      4, 5, 6, 7, 8:      return i_t(i_op[$urandom_range(0, 6)], s, t, im);
      9:  return i_t(6'h23, 5'd0, t, 16'($urandom_range(0, 15) * 4));
      10: return i_t(6'h2b, 5'd0, t, 16'($urandom_range(0, 15) * 4));
      11: return i_t(6'h04, s, t, off);
      12: return i_t(6'h05, s, t, off);
      13: return j_t(6'h02, 26'($urandom_range(0, 127)));
      14: return j_t(6'h03, 26'($urandom_range(0, 127)));
      15: return r_t(6'h08, s, 5'd0, 5'd0, 5'd0);
      16: return i_t(6'h3f, s, t, im);
      default: return r_t(6'h3f, s, t, d, sh);
    endcase
  endfunction

  initial begin
    int loops;
    for (int i = 0; i < 128; i++) m_dm[i] = 32'd0;

    // Arithmetic program, also used for the reset check.
    clear_prog();
    prog[0] = i_t(6'h08, 5'd0, 5'd1, 16'd5);
    prog[1] = i_t(6'h08, 5'd0, 5'd2, 16'hfffd);
    prog[2] = r_t(6'h20, 5'd1, 5'd2, 5'd3, 5'd0);
    prog[3] = r_t(6'h22, 5'd1, 5'd2, 5'd4, 5'd0);
    prog[4] = r_t(6'h2a, 5'd2, 5'd1, 5'd5, 5'd0);
    boot();
    for (int i = 0; i < 32; i++) begin
      reg_sel = 5'(i);
      #1;
      check("reset_reg", reg_data, 32'd0);
    end
    check("reset_pc", dut.PC, 32'd0);
    check("reset_instr", dut.instr, prog[0]);
    run("arith_pc", 5);
    check_reg("arith_r3", 5'd3, 32'd2);
    check_reg("arith_r4", 5'd4, 32'd8);
    check_reg("arith_r5", 5'd5, 32'd1);
    check_reg("arith_r2", 5'd2, 32'hfffffffd);
    check_regs("arith_model");

    // Upper immediate, store and load.
    clear_prog();
    prog[0] = i_t(6'h0f, 5'd0, 5'd1, 16'h1234);
    prog[1] = i_t(6'h0d, 5'd1, 5'd1, 16'h5678);
    prog[2] = i_t(6'h2b, 5'd0, 5'd1, 16'd8);
    prog[3] = i_t(6'h23, 5'd0, 5'd6, 16'd8);
    boot();
    run("mem_pc", 4);
    check_reg("mem_r1", 5'd1, 32'h12345678);
    check_reg("mem_r6", 5'd6, 32'h12345678);

    // Countdown loop.
    clear_prog();
    prog[0] = i_t(6'h08, 5'd0, 5'd1, 16'd3);
    prog[1] = i_t(6'h08, 5'd1, 5'd1, 16'hffff);
    prog[2] = i_t(6'h05, 5'd1, 5'd0, 16'hfffe);
    prog[3] = i_t(6'h08, 5'd0, 5'd2, 16'd7);
    boot();
    loops = 0;
    for (int k = 0; k < 8; k++) begin
      if (dut.PC == 32'd4) loops++;
      m_step();
      @(posedge clk);
      #1;
      check("loop_pc", dut.PC, m_pc);
    end
    check("loop_count", 32'(loops), 32'd3);
    check("loop_end_pc", dut.PC, 32'h10);
    check_reg("loop_r1", 5'd1, 32'd0);
    check_reg("loop_r2", 5'd2, 32'd7);

    // Call and return.
    clear_prog();
    prog[0] = j_t(6'h03, 26'd4);
    prog[4] = i_t(6'h08, 5'd0, 5'd7, 16'd9);
    prog[5] = r_t(6'h08, 5'd31, 5'd0, 5'd0, 5'd0);
    boot();
    run("call_pc", 3);
    check("call_ret_pc", dut.PC, 32'h4);
    check_reg("call_r31", 5'd31, 32'h4);
    check_reg("call_r7", 5'd7, 32'd9);

    // $0 is immutable; then a reset pulse in the middle of a loop.
    clear_prog();
    prog[0] = i_t(6'h08, 5'd0, 5'd0, 16'd1);
    prog[1] = i_t(6'h08, 5'd1, 5'd1, 16'd1);
    prog[2] = j_t(6'h02, 26'd1);
    boot();
    run("zero_pc", 1);
    check_reg("zero_r0", 5'd0, 32'd0);
    run("midrst_pc", 6);
    check_reg("midrst_r1_before", 5'd1, 32'd3);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_pc0", dut.PC, 32'd0);
    check_reg("midrst_r1_clear", 5'd1, 32'd0);
    rstn = 1'b0;
    m_pc = 32'd0;
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    run("midrst_restart", 3);
    check_reg("midrst_r1_after", 5'd1, 32'd1);

    // Random programs: a memory-clearing preamble, then random instructions.
    for (int p = 0; p < 3; p++) begin
      clear_prog();
      for (int i = 0; i < 16; i++) prog[i] = i_t(6'h2b, 5'd0, 5'd0, 16'(i * 4));
      for (int i = 16; i < 128; i++) prog[i] = rand_instr();
      boot();
      run("rand_pc", 300);
      check_regs("rand_regs");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
